// File: rtl/keypad_scan_if.sv
// Signal bundle between the keypad scanner and its consumer (decoder side).
// key_valid is a one-cycle strobe with no back-pressure: the consumer must take {lines,rows} in the cycle it is high.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] line_out;
  logic [3:0] lines;
  logic [3:0] rows;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
  logic [1:0] fsm_state;

  modport master (
    input  row_in,
    output line_out, lines, rows, key_valid, key_held, multi_key, fsm_state
  );

  modport slave (
    output row_in,
    input  line_out, lines, rows, key_valid, key_held, multi_key, fsm_state
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates line drive, snapshots rows per frame and debounces
// whole frames into a stable one-hot {lines,rows} key with press/multi-key status.
module keypad_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int DB_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  keypad_scan_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_FRAMES);

  typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;

  state_t         state;
  logic [3:0]     row_s1, row_s2;
  logic [DW-1:0]  dwell;
  logic [1:0]     col;
  logic [15:0]    snap;
  logic [7:0]     cand;
  logic [CW-1:0]  dbcnt;

  logic [15:0]    frame_bits;
  logic [4:0]     nbits;
  logic [7:0]     code;
  logic           is_none, is_single, frame_end;

  assign kp.fsm_state = state;

  // The line-3 sample is still in row_s2 at frame end, so merge it in here.
  always_comb begin
    frame_bits        = snap;
    frame_bits[15:12] = row_s2;
    nbits             = 5'd0;
    code              = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits[i]) begin
        nbits = nbits + 5'd1;
        code  = {4'b0001 << (i / 4), 4'b0001 << (i % 4)};
      end
    end
  end

  assign is_none   = (nbits == 5'd0);
  assign is_single = (nbits == 5'd1);
  assign frame_end = (dwell == DWELL_LAST) && (col == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row_s1       <= '0;
      row_s2       <= '0;
      dwell        <= '0;
      col          <= '0;
      snap         <= '0;
      cand         <= '0;
      dbcnt        <= '0;
      kp.line_out  <= 4'b0001;
      kp.lines     <= '0;
      kp.rows      <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
      kp.multi_key <= 1'b0;
    end else begin
      row_s1       <= kp.row_in;
      row_s2       <= row_s1;
      kp.key_valid <= 1'b0;

      if (dwell == DWELL_LAST) begin
        dwell                  <= '0;
        snap[{col, 2'b00} +: 4] <= row_s2;
        kp.line_out            <= {kp.line_out[2:0], kp.line_out[3]};
        col                    <= col + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end

      if (frame_end) begin
        snap <= '0;
        case (state)
          IDLE: begin
            if (is_single) begin
              cand <= code;
              if (DB_FRAMES == 1) begin
                state        <= PRESSED;
                dbcnt        <= '0;
                kp.lines     <= code[7:4];
                kp.rows      <= code[3:0];
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
              end else begin
                state <= DEB;
                dbcnt <= CW'(1);
              end
            end
          end
          DEB: begin
            if (is_single && code == cand) begin
              if (dbcnt + CW'(1) == DB_LAST) begin
                state        <= PRESSED;
                dbcnt        <= '0;
                kp.lines     <= cand[7:4];
                kp.rows      <= cand[3:0];
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
              end else begin
                dbcnt <= dbcnt + CW'(1);
              end
            end else begin
              state <= IDLE;
              dbcnt <= '0;
            end
          end
          PRESSED: begin
            if (is_none) begin
              if (DB_FRAMES == 1) begin
                state        <= IDLE;
                dbcnt        <= '0;
                kp.lines     <= '0;
                kp.rows      <= '0;
                kp.key_held  <= 1'b0;
                kp.multi_key <= 1'b0;
              end else begin
                state <= REL;
                dbcnt <= CW'(1);
              end
            end else if (is_single && code == cand) begin
              kp.multi_key <= 1'b0;
            end else begin
              // A different single key counts as extra keys: no re-accept without release.
              kp.multi_key <= 1'b1;
            end
          end
          REL: begin
            if (is_none) begin
              if (dbcnt + CW'(1) == DB_LAST) begin
                state        <= IDLE;
                dbcnt        <= '0;
                kp.lines     <= '0;
                kp.rows      <= '0;
                kp.key_held  <= 1'b0;
                kp.multi_key <= 1'b0;
              end else begin
                dbcnt <= dbcnt + CW'(1);
              end
            end else begin
              state <= PRESSED;
              dbcnt <= '0;
            end
          end
          default: begin
            state <= IDLE;
            dbcnt <= '0;
          end
        endcase
      end
    end
  end
endmodule
